// File: rtl/sdram_read_sched.sv
// Two-requester read scheduler in front of an SDRAM read master: arbitrates, launches one
// transfer at a time and steers the master's user-port FIFO to the owner. Option macro: SDRAM_RD_SCHED_RR_EN.
module sdram_read_sched #(
  parameter int unsigned AW = 25,
  parameter int unsigned DW = 16
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          rq0_req,
  input  logic [AW-1:0] rq0_base,
  input  logic [AW-1:0] rq0_len,
  input  logic          rq0_fixed,
  output logic          rq0_ack,
  output logic          rq0_done,
  input  logic          rq0_rd,
  output logic [DW-1:0] rq0_data,
  output logic          rq0_valid,
  input  logic          rq1_req,
  input  logic [AW-1:0] rq1_base,
  input  logic [AW-1:0] rq1_len,
  input  logic          rq1_fixed,
  output logic          rq1_ack,
  output logic          rq1_done,
  input  logic          rq1_rd,
  output logic [DW-1:0] rq1_data,
  output logic          rq1_valid,
  output logic          ctl_fixed_location,
  output logic [AW-1:0] ctl_read_base,
  output logic [AW-1:0] ctl_read_length,
  output logic          ctl_go,
  input  logic          ctl_done,
  input  logic          ctl_early_done,
  output logic          usr_read_buffer,
  input  logic [DW-1:0] usr_buffer_output_data,
  input  logic          usr_data_available,
  output logic          busy,
  output logic          grant
);

  typedef enum logic [2:0] {IDLE, GO, ARM, BUSY, FIN} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] len_q, len_d;
  logic          fixed_q, fixed_d;
  logic          run_q;
  logic          go_q, busy_q, grant_q, xfer_q;
  logic [1:0]    done_q;
  logic          any_req_c, win_c, accept_c;
  logic          unused_early_done;

  assign unused_early_done = ctl_early_done;
  assign any_req_c = rq0_req | rq1_req;

`ifdef SDRAM_RD_SCHED_RR_EN
  logic last_q, last_d;
  // On a tie the requester not served last wins.
  assign win_c = (rq0_req & rq1_req) ? ~last_q : rq1_req;
`else
  assign win_c = ~rq0_req;
`endif

  // run_q keeps acks quiet while reset is asserted and on the first cycle after release.
  assign accept_c = run_q & (state_q == IDLE) & any_req_c;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    len_d   = len_q;
    fixed_d = fixed_q;
`ifdef SDRAM_RD_SCHED_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = GO;
          owner_d = win_c;
          base_d  = win_c ? rq1_base  : rq0_base;
          len_d   = win_c ? rq1_len   : rq0_len;
          fixed_d = win_c ? rq1_fixed : rq0_fixed;
`ifdef SDRAM_RD_SCHED_RR_EN
          last_d  = win_c;
`endif
        end
      end
      GO:      state_d = (len_q == '0) ? FIN : ARM;
      ARM:     state_d = BUSY;
      BUSY:    if (ctl_done) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      fixed_q <= 1'b0;
      run_q   <= 1'b0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= 1'b0;
      xfer_q  <= 1'b0;
      done_q  <= 2'b00;
`ifdef SDRAM_RD_SCHED_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      len_q   <= len_d;
      fixed_q <= fixed_d;
      run_q   <= 1'b1;
      go_q    <= (state_d == GO) && (len_d != '0);
      busy_q  <= (state_d != IDLE);
      grant_q <= (state_d != IDLE) && owner_d;
      xfer_q  <= (state_d == GO) || (state_d == ARM) || (state_d == BUSY);
      done_q  <= (state_d == FIN) ? {owner_d, ~owner_d} : 2'b00;
`ifdef SDRAM_RD_SCHED_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign rq0_ack            = accept_c & ~win_c;
  assign rq1_ack            = accept_c & win_c;
  assign rq0_done           = done_q[0];
  assign rq1_done           = done_q[1];
  assign ctl_go             = go_q;
  assign ctl_read_base      = base_q;
  assign ctl_read_length    = len_q;
  assign ctl_fixed_location = fixed_q;
  assign busy               = busy_q;
  assign grant              = grant_q;

  // FIFO pops come only from the owner; the non-owner sees no valid data.
  assign usr_read_buffer = xfer_q & usr_data_available & (owner_q ? rq1_rd : rq0_rd);
  assign rq0_valid       = xfer_q & ~owner_q & usr_data_available;
  assign rq1_valid       = xfer_q & owner_q & usr_data_available;
  assign rq0_data        = {DW{run_q}} & usr_buffer_output_data;
  assign rq1_data        = {DW{run_q}} & usr_buffer_output_data;

endmodule

// File: doc/sdram_read_sched.md
SDRAM_READ_SCHED -- requirements
Module: sdram_read_sched

Interface
REQ-001 SHALL have parameter AW, default 25: address and length width, matching the read master control port.
REQ-002 SHALL have parameter DW, default 16: read data width, matching the read master user port.
REQ-003 SHALL have port clk_clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port reset_reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports rqN_req, input, 1 (N=0,1): level request from requester N, held until rqN_ack.
REQ-006 SHALL have ports rqN_base, input, AW: byte start address, sampled at grant.
REQ-007 SHALL have ports rqN_len, input, AW: byte length, sampled at grant.
REQ-008 SHALL have ports rqN_fixed, input, 1: fixed-location flag, sampled at grant.
REQ-009 SHALL have ports rqN_ack, output, 1: one-cycle pulse when the request is accepted.
REQ-010 SHALL have ports rqN_done, output, 1: one-cycle pulse when the granted transfer completes.
REQ-011 SHALL have ports rqN_rd, input, 1: pop strobe from requester N.
REQ-012 SHALL have ports rqN_data, output, DW: read data to requester N.
REQ-013 SHALL have ports rqN_valid, output, 1: rqN_data valid for requester N.
REQ-014 SHALL have ports ctl_fixed_location, output, 1; ctl_read_base, output, AW; ctl_read_length, output, AW; ctl_go, output, 1: read master control.
REQ-015 SHALL have ports ctl_done, input, 1; ctl_early_done, input, 1: master status; ctl_early_done is unused.
REQ-016 SHALL have ports usr_read_buffer, output, 1; usr_buffer_output_data, input, DW; usr_data_available, input, 1: master user port.
REQ-017 SHALL have ports busy, output, 1, and grant, output, 1: owner index while busy.

Function
REQ-018 SHALL use FSM states IDLE, GO, ARM, BUSY, FIN.
REQ-019 IDLE: when any rqN_req is high, select winner per REQ-026, register its base/len/fixed and grant, pulse rqN_ack in the same cycle, go to GO; if registered len is zero, go to FIN instead.
REQ-020 GO: ctl_go high exactly one cycle with registered ctl_* values stable; next ARM.
REQ-021 ARM: one cycle, ctl_done ignored (master deasserts it after go); next BUSY.
REQ-022 BUSY: remain until ctl_done high, then FIN.
REQ-023 FIN: pulse rqN_done for the owner for one cycle; next IDLE; new grant earliest the following cycle.
REQ-024 ctl_read_base/length/fixed SHALL hold their values from grant until the next grant.
REQ-025 In GO, ARM, BUSY: usr_read_buffer = rqG_rd AND usr_data_available for owner G; rqG_valid = usr_data_available; non-owner rd ignored, non-owner valid 0; rqN_data = usr_buffer_output_data for both N.
REQ-026 Arbitration default: fixed priority, rq0 beats rq1 on simultaneous requests.
REQ-027 Requests arriving in any non-IDLE state SHALL stay pending; a request dropped before ack is discarded without side effects.
REQ-028 busy SHALL be high in GO, ARM, BUSY, FIN; grant SHALL be 0 when idle.

Reset
REQ-029 Reset asserted at any time, including mid-transfer, SHALL force IDLE within the same cycle, without a FIN pulse.
REQ-030 Under reset all outputs SHALL be 0, registered base/len/fixed 0, and the round-robin pointer 1.

Configuration
REQ-031 Macro SDRAM_RD_SCHED_RR_EN defined: round-robin; simultaneous requests go to the requester not granted last; pointer updates at each grant.
REQ-032 Macro undefined: fixed priority per REQ-026; no pointer register.

Verification
REQ-033 rq0_req, base=0x100, len=64 -> rq0_ack cycle 0, ctl_go cycle 1 with base 0x100/len 64; after ctl_done rises, rq0_done one cycle later.
REQ-034 rq0 and rq1 requests in the same cycle -> rq0 acked; RR_EN: second simultaneous pair acks rq1, without RR_EN rq0 again.
REQ-035 rq1_req held during rq0 BUSY -> rq1_ack first cycle after rq0_done, no overlapping ctl_go.
REQ-036 len=0 request -> ack, no ctl_go, rqN_done 2 cycles after ack.
REQ-037 rq1_rd high while rq0 owns with usr_data_available=1 -> usr_read_buffer follows rq0_rd only, rq1_valid 0.
REQ-038 reset_reset_n low during BUSY -> all outputs 0 immediately, no rqN_done, next request served normally.
